// File: rtl/load_store_unit.sv
// Load/store unit: the core's only path to the data memory.
// Takes one LDUR/STUR request at a time and forms the word address from
// base plus the signed 9-bit offset. It drives the memory strobes and
// returns a completion through a valid/ready handshake.
module load_store_unit #(
   parameter int MEM_WORDS    = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [63:0] req_base,
   input  logic [8:0]  req_offset,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_error,
   output logic [63:0] Address,
   output logic [63:0] WriteData,
   output logic        MemRead,
   output logic        MemWrite,
   input  logic [63:0] ReadData
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   localparam logic [2:0] LastReadCnt = 3'(READ_LATENCY - 1);

   state_t      state_q, state_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] rdata_q, rdata_d;
   logic        error_q, error_d;
   logic [2:0]  cnt_q, cnt_d;

   logic [63:0] byteAddr;
   logic        isMisaligned;
   logic        isOutOfRange;
   logic        isError;

   // Byte address wraps modulo 2^64, so an underflow lands far out of range.
   always_comb begin
      byteAddr     = req_base + {{55{req_offset[8]}}, req_offset};
      isMisaligned = (byteAddr[2:0] != 3'b000);
      isOutOfRange = (byteAddr[63:3] >= 61'(MEM_WORDS));
      isError      = isMisaligned || isOutOfRange;
   end

   // State and datapath registers; reset drops the strobes at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: erroring requests skip the memory and go straight to RESP.
   // Address/WriteData are left untouched on an error so the pins stay quiet.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      error_d = error_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               rdata_d = '0;
               error_d = isError;
               cnt_d   = '0;
               if (isError) begin
                  state_d = RESP;
               end else begin
                  addr_d  = {3'b000, byteAddr[63:3]};
                  wdata_d = req_wdata;
                  state_d = req_is_store ? WRITE : READ;
               end
            end
         end
         WRITE: begin
            state_d = RESP;
         end
         READ: begin
            if (cnt_q == LastReadCnt) begin
               rdata_d = ReadData;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               rdata_d = '0;
               error_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode straight from the state register, so MemRead always
   // drops for at least the RESP and IDLE cycles between consecutive loads.
   always_comb begin
      req_ready  = (state_q == IDLE);
      resp_valid = (state_q == RESP);
      MemRead    = (state_q == READ);
      MemWrite   = (state_q == WRITE);
      Address    = addr_q;
      WriteData  = wdata_q;
      resp_rdata = rdata_q;
      resp_error = error_q;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a 32-word memory model.
module tb_load_store_unit;

   localparam int LAT = 3;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [63:0] req_base;
   logic [8:0]  req_offset;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_error;
   logic [63:0] Address;
   logic [63:0] WriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [63:0] ReadData;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sbq[$];
   logic [63:0] mem [32];
   logic [63:0] refMem [32];
   int          compared = 0;
   int          mismatched = 0;

   int          readCycles = 0;
   int          writeCycles = 0;
   int          curRun = 0;
   int          runs[$];
   logic [63:0] lastStrobeAddr = '0;
   logic [63:0] lastWriteData = '0;

   load_store_unit #(.MEM_WORDS(32), .READ_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_error(resp_error),
      .Address(Address), .WriteData(WriteData),
      .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: level-sensitive read, write on the rising edge.
   assign ReadData = (Address < 64'd32) ? mem[Address[4:0]] : 64'd0;
   always @(posedge clk) begin
      if (MemWrite && Address < 64'd32) mem[Address[4:0]] <= WriteData;
   end

   // Strobe monitor: counts strobe cycles and records MemRead run lengths.
   always @(negedge clk) begin
      if (MemRead) begin
         readCycles++;
         curRun++;
         lastStrobeAddr = Address;
      end else if (curRun != 0) begin
         runs.push_back(curRun);
         curRun = 0;
      end
      if (MemWrite) begin
         writeCycles++;
         lastStrobeAddr = Address;
         lastWriteData  = WriteData;
      end
   end

   // Drive one request, wait for it to be accepted, push the expected response.
   task automatic sendReq(input bit st, input logic [63:0] base, input logic [8:0] off,
                          input logic [63:0] wd);
      logic [63:0] ba;
      bit          err;
      bit          ok;
      exp_t        e;
      ba  = base + {{55{off[8]}}, off};
      err = (ba[2:0] != 3'b000) || (ba[63:3] >= 61'd32);
      e.err   = err;
      e.rdata = (err || st) ? 64'd0 : refMem[ba[7:3]];
      @(negedge clk);
      req_valid = 1'b1; req_is_store = st; req_base = base; req_offset = off; req_wdata = wd;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (req_ready === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
      req_valid = 1'b0;
      if (ok) begin
         sbq.push_back(e);
         if (st && !err) refMem[ba[7:3]] = wd;
      end else begin
         compared++; mismatched++;
         $display("[TB] FAIL accept_timeout: req_ready never high, required 1");
      end
   endtask

   // Wait for a completion and accept it; returns observed values.
   task automatic waitResp(output logic [63:0] rd, output logic er);
      bit ok;
      ok = 1'b0; rd = 'x; er = 'x;
      for (int i = 0; i < 60; i++) begin
         if (resp_valid === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (ok) begin
         rd = resp_rdata; er = resp_error;
         resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
      end else begin
         compared++; mismatched++;
         $display("[TB] FAIL resp_timeout: resp_valid never high, required 1");
      end
   endtask

   task automatic test_reset;
      #3;
      compared++;
      if ({req_ready, resp_valid, MemRead, MemWrite, resp_error, Address, WriteData, resp_rdata}
          !== {1'b1, 4'b0000, 192'd0}) begin
         mismatched++;
         $display("[TB] FAIL reset_values: got rdy=%b vld=%b rd=%b wr=%b err=%b addr=%h wd=%h rdata=%h, required 1 0 0 0 0 0 0 0",
                  req_ready, resp_valid, MemRead, MemWrite, resp_error, Address, WriteData, resp_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_store_load;
      logic [63:0] rd; logic er; exp_t e; int w0, r0;
      w0 = writeCycles;
      sendReq(1'b1, 64'h10, 9'd8, 64'hDEADBEEF);
      waitResp(rd, er); e = sbq.pop_front();
      compared++;
      if ({rd, er} !== {e.rdata, e.err}) begin mismatched++;
         $display("[TB] FAIL store_resp: got %h/%b required %h/%b", rd, er, e.rdata, e.err); end
      compared++;
      if (writeCycles - w0 !== 1) begin mismatched++;
         $display("[TB] FAIL store_strobe_cycles: got %0d required 1", writeCycles - w0); end
      compared++;
      if ({lastStrobeAddr, lastWriteData} !== {64'd3, 64'hDEADBEEF}) begin mismatched++;
         $display("[TB] FAIL store_addr_data: got %h/%h required 3/deadbeef", lastStrobeAddr, lastWriteData); end
      r0 = readCycles;
      sendReq(1'b0, 64'h10, 9'd8, 64'd0);
      waitResp(rd, er); e = sbq.pop_front();
      compared++;
      if ({rd, er} !== {64'hDEADBEEF, 1'b0} || e.rdata !== 64'hDEADBEEF) begin mismatched++;
         $display("[TB] FAIL load_resp: got %h/%b required deadbeef/0", rd, er); end
      compared++;
      if (readCycles - r0 !== LAT || lastStrobeAddr !== 64'd3) begin mismatched++;
         $display("[TB] FAIL load_strobe: got %0d cycles addr %h required %0d cycles addr 3",
                  readCycles - r0, lastStrobeAddr, LAT); end
   endtask

   task automatic test_neg_offset;
      logic [63:0] rd; logic er; exp_t e;
      sendReq(1'b1, 64'h40, 9'h1F0, 64'h1234);
      waitResp(rd, er); e = sbq.pop_front();
      compared++;
      if (lastStrobeAddr !== 64'd6 || {rd, er} !== {e.rdata, e.err}) begin mismatched++;
         $display("[TB] FAIL neg_store: got addr %h resp %h/%b required addr 6 resp 0/0", lastStrobeAddr, rd, er); end
      sendReq(1'b0, 64'h40, 9'h1F0, 64'd0);
      waitResp(rd, er); e = sbq.pop_front();
      compared++;
      if ({rd, er} !== {64'h1234, 1'b0} || lastStrobeAddr !== 64'd6) begin mismatched++;
         $display("[TB] FAIL neg_load: got %h/%b addr %h required 1234/0 addr 6", rd, er, lastStrobeAddr); end
   endtask

   typedef struct {
      bit          st;
      logic [63:0] base;
      logic [8:0]  off;
      logic [63:0] word;
   } vec_t;

   task automatic test_errors;
      vec_t vecs[5];
      logic [63:0] rd; logic er; exp_t e; int w0, r0;
      vecs[0] = '{st: 1'b0, base: 64'h10,  off: 9'd4,   word: 64'd0};
      vecs[1] = '{st: 1'b1, base: 64'h100, off: 9'd0,   word: 64'd0};
      vecs[2] = '{st: 1'b0, base: 64'h0,   off: 9'h1F8, word: 64'd0};
      vecs[3] = '{st: 1'b1, base: 64'h100, off: 9'h100, word: 64'd0};
      vecs[4] = '{st: 1'b1, base: 64'hFFFF_FFFF_FFFF_FFF9, off: 9'h0FF, word: 64'd31};
      foreach (vecs[i]) begin
         w0 = writeCycles; r0 = readCycles;
         sendReq(vecs[i].st, vecs[i].base, vecs[i].off, 64'hC0DE_0000 + 64'(i));
         waitResp(rd, er); e = sbq.pop_front();
         compared++;
         if ({rd, er} !== {e.rdata, e.err}) begin mismatched++;
            $display("[TB] FAIL err_resp_%0d: got %h/%b required %h/%b", i, rd, er, e.rdata, e.err); end
         compared++;
         if (e.err ? (writeCycles != w0 || readCycles != r0)
                   : (writeCycles - w0 != 1 || lastStrobeAddr !== vecs[i].word)) begin mismatched++;
            $display("[TB] FAIL err_strobe_%0d: got wr %0d rd %0d addr %h required err=%b word %h",
                     i, writeCycles - w0, readCycles - r0, lastStrobeAddr, e.err, vecs[i].word); end
      end
   endtask

   task automatic test_backpressure;
      logic [63:0] rd; logic er; exp_t e, e2; bit seen;
      sendReq(1'b0, 64'h18, 9'd0, 64'd0);
      e = sbq.pop_front();
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (resp_valid === 1'b1) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      compared++;
      if (!seen) begin mismatched++; $display("[TB] FAIL bp_wait: resp_valid 0 required 1"); end
      req_valid = 1'b1; req_is_store = 1'b0; req_base = 64'h30; req_offset = 9'd0; req_wdata = '0;
      e2.rdata = refMem[6]; e2.err = 1'b0;
      for (int i = 0; i < 5; i++) begin
         compared++;
         if ({resp_valid, req_ready, resp_rdata, resp_error} !== {1'b1, 1'b0, e.rdata, e.err}) begin
            mismatched++;
            $display("[TB] FAIL bp_hold_%0d: got vld=%b rdy=%b %h/%b required 1 0 %h/%b",
                     i, resp_valid, req_ready, resp_rdata, resp_error, e.rdata, e.err);
         end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      compared++;
      if ({req_ready, resp_valid} !== 2'b10) begin mismatched++;
         $display("[TB] FAIL bp_idle: got rdy=%b vld=%b required 1 0", req_ready, resp_valid); end
      @(negedge clk);
      req_valid = 1'b0;
      sbq.push_back(e2);
      compared++;
      if ({req_ready, MemRead, Address} !== {1'b0, 1'b1, 64'd6}) begin mismatched++;
         $display("[TB] FAIL bp_accept: got rdy=%b rd=%b addr=%h required 0 1 6", req_ready, MemRead, Address); end
      waitResp(rd, er); e2 = sbq.pop_front();
      compared++;
      if ({rd, er} !== {64'h1234, 1'b0} || e2.rdata !== 64'h1234) begin mismatched++;
         $display("[TB] FAIL bp_second_load: got %h/%b required 1234/0", rd, er); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] rd; logic er; exp_t e; int n0;
      for (int k = 0; k < 3; k++) begin
         sendReq(1'b1, 64'(8 * (10 + k)), 9'd0, 64'hA000 + 64'(k * 17));
         waitResp(rd, er); e = sbq.pop_front();
         compared++;
         if ({rd, er} !== {e.rdata, e.err}) begin mismatched++;
            $display("[TB] FAIL b2b_store_%0d: got %h/%b required %h/%b", k, rd, er, e.rdata, e.err); end
      end
      n0 = runs.size();
      fork
         for (int k = 0; k < 3; k++) sendReq(1'b0, 64'(8 * (10 + k)), 9'd0, 64'd0);
         for (int k = 0; k < 3; k++) begin
            waitResp(rd, er); e = sbq.pop_front();
            compared++;
            if ({rd, er} !== {64'hA000 + 64'(k * 17), 1'b0}) begin mismatched++;
               $display("[TB] FAIL b2b_load_%0d: got %h/%b required %h/0", k, rd, er, 64'hA000 + 64'(k * 17)); end
         end
      join
      compared++;
      if (runs.size() - n0 !== 3) begin mismatched++;
         $display("[TB] FAIL b2b_run_count: got %0d required 3", runs.size() - n0); end
      for (int k = n0; k < runs.size(); k++) begin
         compared++;
         if (runs[k] !== LAT) begin mismatched++;
            $display("[TB] FAIL b2b_run_len: got %0d required %0d", runs[k], LAT); end
      end
   endtask

   task automatic test_async_reset;
      logic [63:0] rd; logic er; exp_t e;
      sendReq(1'b1, 64'h28, 9'd0, 64'hAAAA);
      waitResp(rd, er); e = sbq.pop_front();
      sendReq(1'b1, 64'h28, 9'd0, 64'h5555);
      compared++;
      if (MemWrite !== 1'b1) begin mismatched++;
         $display("[TB] FAIL rst_in_write: MemWrite got %b required 1", MemWrite); end
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if ({MemWrite, resp_valid, req_ready} !== 3'b001) begin mismatched++;
         $display("[TB] FAIL rst_async: got wr=%b vld=%b rdy=%b required 0 0 1", MemWrite, resp_valid, req_ready); end
      void'(sbq.pop_back());
      refMem[5] = 64'hAAAA;
      @(negedge clk);
      rst_n = 1'b1;
      sendReq(1'b0, 64'h28, 9'd0, 64'd0);
      waitResp(rd, er); e = sbq.pop_front();
      compared++;
      if ({rd, er} !== {64'hAAAA, 1'b0} || e.rdata !== 64'hAAAA) begin mismatched++;
         $display("[TB] FAIL rst_readback: got %h/%b required aaaa/0", rd, er); end
   endtask

   // Test sequence.
   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_base = '0;
      req_offset = '0; req_wdata = '0; resp_ready = 1'b0;
      test_reset;
      test_store_load;
      test_neg_offset;
      test_errors;
      test_backpressure;
      test_back_to_back;
      test_async_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
